clint_rtc_gen: RTL

Real-time clock generator that sits directly upstream of the CLINT and drives its `rt_clk` input. A 32-bit phase accumulator (NCO) clocked by the system clock synthesizes a nominal 32.768 kHz square wave from an arbitrary `clk` frequency. A small memory-mapped register port on the same valid/ready bus lets software enable it, trim the rate and read an edge counter.

---
 rtl/clint_rtc_gen.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/clint_rtc_gen.sv
// clint_rtc_gen: real-time clock generator feeding the CLINT rt_clk input.
// A 32-bit phase accumulator (NCO) advanced by INC every clk cycle produces a
// nominal 32.768 kHz square wave on rt_clk (registered acc[31]). A small
// valid/ready register port gives software enable/clear, rate trim and a
// rising-edge counter.
//
// Build option: define CLINT_RTC_TRIM_EN to make INC writable at runtime;
// otherwise INC is hardwired to INC_DEFAULT and writes to 0x4 are ignored.
//
// Ports:
//   clk      system clock
//   reset    synchronous, active-high reset
//   valid    request valid
//   address  request address (only address[3:2] decoded)
//   wdata    write data
//   wstrb    write strobes; a write happens only when all ones
//   rdata    read data, valid while ready=1
//   ready    one-cycle response pulse, one cycle after valid
//   rt_clk   generated real-time clock
//   rt_tick  one-clk pulse in the cycle rt_clk rises
//
// Register map (address[3:2]):
//   0x0 CTRL  bit0 enable (RW), bit1 clear (write-1 pulse, reads 0)
//   0x4 INC   phase increment, bit 31 forced to 0
//   0x8 ACC   accumulator (RO)
//   0xC EDGES rising-edge count (RW)
module clint_rtc_gen #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter logic [31:0] INC_DEFAULT = 32'h0015_798F,
  parameter logic        EN_DEFAULT  = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   rdata,
  output logic                ready,
  output logic                rt_clk,
  output logic                rt_tick
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned SEL_W  = 2;

  localparam logic [SEL_W-1:0] REG_CTRL  = 2'd0;
  localparam logic [SEL_W-1:0] REG_INC   = 2'd1;
  localparam logic [SEL_W-1:0] REG_ACC   = 2'd2;
  localparam logic [SEL_W-1:0] REG_EDGES = 2'd3;

  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] edges_q;
  logic              enable_q;
  logic [DATA_W-1:0] inc_c;

  logic              wr_c;
  logic [SEL_W-1:0]  sel_c;
  logic              clear_c;
  logic [DATA_W-1:0] acc_nxt_c;
  logic              tick_c;
  logic [DATA_W-1:0] rdata_c;

  // Address bits outside [3:2] carry no meaning for this block.
  logic unused_addr_c;
  assign unused_addr_c = ^{address[ADDR_W-1:4], address[1:0]};

`ifdef CLINT_RTC_TRIM_EN
  logic [DATA_W-1:0] inc_q;

  // Runtime-trimmable increment; bit 31 kept clear so at most one edge per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      inc_q <= DATA_W'(INC_DEFAULT);
    end else if (wr_c && (sel_c == REG_INC)) begin
      inc_q <= {1'b0, wdata[DATA_W-2:0]};
    end
  end

  assign inc_c = inc_q;
`else
  assign inc_c = DATA_W'(INC_DEFAULT);
`endif

  // Request decode, NCO next state, edge detect and read mux.
  always_comb begin
    wr_c      = valid && (wstrb == {STRB_W{1'b1}});
    sel_c     = address[3:2];
    clear_c   = wr_c && (sel_c == REG_CTRL) && wdata[1];
    acc_nxt_c = acc_q;
    tick_c    = 1'b0;
    rdata_c   = '0;

    // Clear overrides accumulation and lands acc at 0, so it never ticks.
    if (clear_c) begin
      acc_nxt_c = '0;
    end else if (enable_q) begin
      acc_nxt_c = acc_q + inc_c;
    end

    tick_c = !rt_clk && acc_nxt_c[DATA_W-1];

    unique case (sel_c)
      REG_CTRL:  rdata_c = DATA_W'(enable_q);
      REG_INC:   rdata_c = inc_c;
      REG_ACC:   rdata_c = acc_q;
      REG_EDGES: rdata_c = edges_q;
      default:   rdata_c = '0;
    endcase
  end

  // NCO state, rt_clk/rt_tick outputs and the edge counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q    <= '0;
      rt_clk   <= 1'b0;
      rt_tick  <= 1'b0;
      edges_q  <= '0;
      enable_q <= EN_DEFAULT;
    end else begin
      acc_q   <= acc_nxt_c;
      rt_clk  <= acc_nxt_c[DATA_W-1];
      rt_tick <= tick_c;

      if (wr_c && (sel_c == REG_CTRL)) begin
        enable_q <= wdata[0];
      end

      // A software load takes priority over a coincident tick.
      if (wr_c && (sel_c == REG_EDGES)) begin
        edges_q <= wdata;
      end else if (tick_c) begin
        edges_q <= edges_q + DATA_W'(1);
      end
    end
  end

  // Single-cycle response; reset drops any in-flight acknowledge.
  always_ff @(posedge clk) begin
    if (reset) begin
      ready <= 1'b0;
      rdata <= '0;
    end else begin
      ready <= valid;
      rdata <= valid ? rdata_c : '0;
    end
  end

endmodule
